csa: RTL and testbench



---
 rtl/csa_pkg.sv | 8 +
 rtl/csa_rca_block.sv | 26 ++
 rtl/csa.sv | 73 +++++++
 tb/tb_csa.sv | 119 +++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared sizing constants for the carry-select adder.
package csa_pkg;

    localparam int CSA_WIDTH = 16;
    localparam int CSA_BLOCK = 4;
    localparam int CSA_NBLK  = CSA_WIDTH / CSA_BLOCK;

endpackage

// File: rtl/csa_rca_block.sv
// BLOCK-bit ripple-carry adder slice built from full-adder equations.
module rca_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] sum,
    output logic             co
);

    logic [BLOCK:0] carry_s;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
        co = carry_s[BLOCK];
    end

endmodule

// File: rtl/csa.sv
// Registered carry-select adder: {cout, S} = x + y + cin, one cycle of latency.
module csa
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLOCK;

    logic [NBLK:0]    carry_s;
    logic [WIDTH-1:0] sum_s;

    assign carry_s[0] = cin;

    // Block 0 ripples directly from cin; higher blocks precompute both
    // carry-in cases and let the incoming carry pick one.
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_first
            rca_block #(.BLOCK(BLOCK)) u_rca (
                .a   (x[BLOCK-1:0]),
                .b   (y[BLOCK-1:0]),
                .ci  (carry_s[0]),
                .sum (sum_s[BLOCK-1:0]),
                .co  (carry_s[1])
            );
        end else begin : g_sel
            logic [BLOCK-1:0] sum0_s;
            logic [BLOCK-1:0] sum1_s;
            logic             co0_s;
            logic             co1_s;

            rca_block #(.BLOCK(BLOCK)) u_rca0 (
                .a   (x[k*BLOCK +: BLOCK]),
                .b   (y[k*BLOCK +: BLOCK]),
                .ci  (1'b0),
                .sum (sum0_s),
                .co  (co0_s)
            );

            rca_block #(.BLOCK(BLOCK)) u_rca1 (
                .a   (x[k*BLOCK +: BLOCK]),
                .b   (y[k*BLOCK +: BLOCK]),
                .ci  (1'b1),
                .sum (sum1_s),
                .co  (co1_s)
            );

            assign sum_s[k*BLOCK +: BLOCK] = carry_s[k] ? sum1_s : sum0_s;
            assign carry_s[k+1]            = carry_s[k] ? co1_s  : co0_s;
        end
    end

    // Output register; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            cout <= 1'b0;
        end else begin
            S    <= sum_s;
            cout <= carry_s[NBLK];
        end
    end

endmodule

// File: tb/tb_csa.sv
// Directed and random bench for csa against an arithmetic reference model.
module tb_csa;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic [15:0] S;
    logic        cout;

    int checks   = 0;
    int failures = 0;
    logic [16:0] model_sum = 17'd0;

    csa dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .cin   (cin),
        .S     (S),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: result of the operands present at the last rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_sum <= 17'd0;
        else        model_sum <= {1'b0, x} + {1'b0, y} + {16'd0, cin};
    end

    // Continuous comparison on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        checks++;
        if ({cout, S} !== model_sum) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, {cout, S}, model_sum);
        end
    end

    task automatic check_lit(input string name, input logic [16:0] exp);
        checks++;
        if ({cout, S} !== exp) begin
            failures++;
            $display("FAIL %s dut=%h expected=%h", name, {cout, S}, exp);
        end
        checks++;
        if (model_sum !== exp) begin
            failures++;
            $display("FAIL %s_model model=%h expected=%h", name, model_sum, exp);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [16:0] exp, input string name);
        x   = a;
        y   = b;
        cin = c;
        @(posedge clk);
        #2;
        check_lit(name, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        x     = 16'h1234;
        y     = 16'h1111;
        cin   = 1'b0;
        #1;
        check_lit("reset_async", 17'h00000);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check_lit("first_after_reset", 17'h02345);

        step(16'h0000, 16'h0000, 1'b0, 17'h00000, "zero");
        step(16'h0003, 16'h0004, 1'b0, 17'h00007, "small_3_4");
        step(16'h0005, 16'h0008, 1'b0, 17'h0000D, "small_5_8");
        step(16'hFFFF, 16'h0000, 1'b1, 17'h10000, "full_prop_cin");
        step(16'h0FFF, 16'h0001, 1'b0, 17'h01000, "prop_12bit");
        step(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "max_cin1");
        step(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, "max_cin0");
        step(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, "max_hold");
        step(16'h8000, 16'h8000, 1'b0, 17'h10000, "msb_carry");
        step(16'h1234, 16'hEDCB, 1'b1, 17'h10000, "complement_cin");
        step(16'h00F0, 16'h0010, 1'b0, 17'h00100, "block1_carry");
        step(16'hABCD, 16'h1111, 1'b1, 17'h0BCDF, "mixed");

        // Mid-stream asynchronous reset between edges.
        x   = 16'h7777;
        y   = 16'h1111;
        cin = 1'b0;
        rst_n = 1'b0;
        #1;
        check_lit("mid_reset_async", 17'h00000);
        @(posedge clk);
        #2;
        check_lit("mid_reset_held", 17'h00000);
        rst_n = 1'b1;
        step(16'h7777, 16'h1111, 1'b0, 17'h08888, "after_mid_reset");

        for (int i = 0; i < 1000; i++) begin
            x   = 16'($urandom_range(0, 65535));
            y   = 16'($urandom_range(0, 65535));
            cin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
